// File: rtl/rggen_apb_if.sv
// rtl/rggen_apb_if.sv - APB3/APB4 bus bundle with master and slave views.
interface rggen_apb_if #(
   parameter int ADDRESS_WIDTH = 16,
   parameter int DATA_WIDTH    = 32
);
   logic                      psel;
   logic                      penable;
   logic [ADDRESS_WIDTH-1:0]  paddr;
   logic                      pwrite;
   logic [DATA_WIDTH-1:0]     pwdata;
   logic [DATA_WIDTH/8-1:0]   pstrb;
   logic                      pready;
   logic [DATA_WIDTH-1:0]     prdata;
   logic                      pslverr;

   modport master (
      output psel, penable, paddr, pwrite, pwdata, pstrb,
      input  pready, prdata, pslverr
   );

   modport slave (
      input  psel, penable, paddr, pwrite, pwdata, pstrb,
      output pready, prdata, pslverr
   );
endinterface

// File: rtl/rggen_apb_master_bridge.sv
// rtl/rggen_apb_master_bridge.sv - valid/ready command stream to APB initiator.
// One transfer in flight; optional ACCESS-phase timeout aborts a stuck slave.
module rggen_apb_master_bridge #(
   parameter int ADDRESS_WIDTH  = 16,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 0
)(
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      cmd_valid,
   output logic                      cmd_ready,
   input  logic [ADDRESS_WIDTH-1:0]  cmd_address,
   input  logic                      cmd_write,
   input  logic [DATA_WIDTH-1:0]     cmd_write_data,
   input  logic [DATA_WIDTH/8-1:0]   cmd_strobe,
   output logic                      rsp_valid,
   input  logic                      rsp_ready,
   output logic [DATA_WIDTH-1:0]     rsp_read_data,
   output logic                      rsp_error,
   output logic                      rsp_timeout,
   rggen_apb_if.master               apb_if
);
   localparam int STRB_WIDTH  = DATA_WIDTH / 8;
   localparam int COUNT_WIDTH = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
   localparam int LAST_VALUE  = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
   localparam logic [COUNT_WIDTH-1:0] COUNT_LAST = LAST_VALUE[COUNT_WIDTH-1:0];
   localparam logic [COUNT_WIDTH-1:0] COUNT_MAX  = {COUNT_WIDTH{1'b1}};

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      SETUP    = 2'd1,
      ACCESS   = 2'd2,
      RESPONSE = 2'd3
   } state_e;

   state_e                    state_q, state_d;
   logic                      psel_q, psel_d;
   logic                      penable_q, penable_d;
   logic [ADDRESS_WIDTH-1:0]  paddr_q, paddr_d;
   logic                      pwrite_q, pwrite_d;
   logic [DATA_WIDTH-1:0]     pwdata_q, pwdata_d;
   logic [STRB_WIDTH-1:0]     pstrb_q, pstrb_d;
   logic                      rsp_valid_q, rsp_valid_d;
   logic [DATA_WIDTH-1:0]     rsp_read_data_q, rsp_read_data_d;
   logic                      rsp_error_q, rsp_error_d;
   logic                      rsp_timeout_q, rsp_timeout_d;
   logic [COUNT_WIDTH-1:0]    count_q, count_d;
   logic                      timeout_hit;

   // Counter holds (ACCESS cycle number - 1), so the last allowed cycle is COUNT_LAST.
   assign timeout_hit = (TIMEOUT_CYCLES != 0) && (count_q == COUNT_LAST);
   assign cmd_ready   = (state_q == IDLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:     if (cmd_valid) state_d = SETUP;
         SETUP:    state_d = ACCESS;
         ACCESS:   if (apb_if.pready || timeout_hit) state_d = RESPONSE;
         RESPONSE: if (rsp_ready) state_d = IDLE;
         default:  state_d = IDLE;
      endcase
   end

   always_comb begin
      psel_d          = psel_q;
      penable_d       = penable_q;
      paddr_d         = paddr_q;
      pwrite_d        = pwrite_q;
      pwdata_d        = pwdata_q;
      pstrb_d         = pstrb_q;
      rsp_valid_d     = rsp_valid_q;
      rsp_read_data_d = rsp_read_data_q;
      rsp_error_d     = rsp_error_q;
      rsp_timeout_d   = rsp_timeout_q;
      count_d         = count_q;
      case (state_q)
         IDLE: begin
            if (cmd_valid) begin
               paddr_d   = cmd_address;
               pwrite_d  = cmd_write;
               pwdata_d  = cmd_write ? cmd_write_data : '0;
               pstrb_d   = cmd_write ? cmd_strobe : '0;
               psel_d    = 1'b1;
               penable_d = 1'b0;
            end
         end
         SETUP: begin
            penable_d = 1'b1;
            count_d   = '0;
         end
         ACCESS: begin
            // pready takes priority over a timeout firing in the same cycle
            if (apb_if.pready) begin
               rsp_read_data_d = pwrite_q ? '0 : apb_if.prdata;
               rsp_error_d     = apb_if.pslverr;
               rsp_timeout_d   = 1'b0;
               psel_d          = 1'b0;
               penable_d       = 1'b0;
               rsp_valid_d     = 1'b1;
            end else if (timeout_hit) begin
               rsp_read_data_d = '0;
               rsp_error_d     = 1'b1;
               rsp_timeout_d   = 1'b1;
               psel_d          = 1'b0;
               penable_d       = 1'b0;
               rsp_valid_d     = 1'b1;
            end else if (count_q != COUNT_MAX) begin
               count_d = count_q + COUNT_WIDTH'(1);
            end
         end
         RESPONSE: begin
            if (rsp_ready) rsp_valid_d = 1'b0;
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         psel_q          <= 1'b0;
         penable_q       <= 1'b0;
         paddr_q         <= '0;
         pwrite_q        <= 1'b0;
         pwdata_q        <= '0;
         pstrb_q         <= '0;
         rsp_valid_q     <= 1'b0;
         rsp_read_data_q <= '0;
         rsp_error_q     <= 1'b0;
         rsp_timeout_q   <= 1'b0;
         count_q         <= '0;
      end else begin
         psel_q          <= psel_d;
         penable_q       <= penable_d;
         paddr_q         <= paddr_d;
         pwrite_q        <= pwrite_d;
         pwdata_q        <= pwdata_d;
         pstrb_q         <= pstrb_d;
         rsp_valid_q     <= rsp_valid_d;
         rsp_read_data_q <= rsp_read_data_d;
         rsp_error_q     <= rsp_error_d;
         rsp_timeout_q   <= rsp_timeout_d;
         count_q         <= count_d;
      end
   end

   assign apb_if.psel    = psel_q;
   assign apb_if.penable = penable_q;
   assign apb_if.paddr   = paddr_q;
   assign apb_if.pwrite  = pwrite_q;
   assign apb_if.pwdata  = pwdata_q;
   assign apb_if.pstrb   = pstrb_q;
   assign rsp_valid      = rsp_valid_q;
   assign rsp_read_data  = rsp_read_data_q;
   assign rsp_error      = rsp_error_q;
   assign rsp_timeout    = rsp_timeout_q;
endmodule

// File: tb/tb_rggen_apb_master_bridge.sv
// tb/tb_rggen_apb_master_bridge.sv - directed self-checking bench for the APB master bridge.
module tb_rggen_apb_master_bridge;
   logic        clk;
   logic        rst;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [15:0] cmd_address;
   logic        cmd_write;
   logic [31:0] cmd_write_data;
   logic [3:0]  cmd_strobe;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_read_data;
   logic        rsp_error;
   logic        rsp_timeout;

   int checks = 0;
   int errors = 0;

   int          r_lat, r_psel_at, r_en_at, r_en_cycles, r_unstable;
   logic [15:0] cap_paddr;
   logic        cap_pwrite;
   logic [31:0] cap_pwdata;
   logic [3:0]  cap_pstrb;

   rggen_apb_if #(.ADDRESS_WIDTH(16), .DATA_WIDTH(32)) apb ();

   rggen_apb_master_bridge #(
      .ADDRESS_WIDTH (16),
      .DATA_WIDTH    (32),
      .TIMEOUT_CYCLES(4)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .cmd_valid     (cmd_valid),
      .cmd_ready     (cmd_ready),
      .cmd_address   (cmd_address),
      .cmd_write     (cmd_write),
      .cmd_write_data(cmd_write_data),
      .cmd_strobe    (cmd_strobe),
      .rsp_valid     (rsp_valid),
      .rsp_ready     (rsp_ready),
      .rsp_read_data (rsp_read_data),
      .rsp_error     (rsp_error),
      .rsp_timeout   (rsp_timeout),
      .apb_if        (apb)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   // Issues one command at the current negedge and plays the slave until rsp_valid.
   // The cycle in which the command is presented is cycle 0.
   task automatic run_xfer(input logic [15:0] addr, input logic wr, input logic [31:0] wd,
                           input logic [3:0] st, input int ready_at, input logic [31:0] rd,
                           input logic sle);
      cmd_valid = 1'b1; cmd_address = addr; cmd_write = wr; cmd_write_data = wd; cmd_strobe = st;
      apb.pready = 1'b0; apb.prdata = rd; apb.pslverr = sle;
      r_lat = 0; r_psel_at = -1; r_en_at = -1; r_en_cycles = 0; r_unstable = 0;
      @(negedge clk);
      cmd_valid = 1'b0;
      r_lat = 1;
      while (!rsp_valid && r_lat < 30) begin
         apb.pready = 1'b0;
         if (apb.psel && r_psel_at < 0) r_psel_at = r_lat;
         if (apb.penable) begin
            if (r_en_cycles == 0) begin
               r_en_at = r_lat;
               cap_paddr = apb.paddr; cap_pwrite = apb.pwrite;
               cap_pwdata = apb.pwdata; cap_pstrb = apb.pstrb;
            end else if ({apb.psel, apb.paddr, apb.pwrite, apb.pwdata, apb.pstrb} !==
                         {1'b1, cap_paddr, cap_pwrite, cap_pwdata, cap_pstrb}) begin
               r_unstable = 1;
            end
            r_en_cycles++;
            if (r_en_cycles == ready_at) apb.pready = 1'b1;
         end
         @(negedge clk);
         r_lat++;
      end
      apb.pready = 1'b0; apb.pslverr = 1'b0;
   endtask

   task automatic release_rsp;
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
   endtask

   task automatic test_reset;
      @(negedge clk);
      checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready: got %b expected 1", cmd_ready); end
      checks++; if (apb.psel !== 1'b0 || apb.penable !== 1'b0) begin errors++; $display("FAIL reset_psel_penable: got %b%b expected 00", apb.psel, apb.penable); end
      checks++; if (apb.paddr !== 16'h0 || apb.pwrite !== 1'b0 || apb.pwdata !== 32'h0 || apb.pstrb !== 4'h0) begin errors++; $display("FAIL reset_apb_regs: paddr %h pwrite %b pwdata %h pstrb %h expected all zero", apb.paddr, apb.pwrite, apb.pwdata, apb.pstrb); end
      checks++; if ({rsp_valid, rsp_error, rsp_timeout} !== 3'b000 || rsp_read_data !== 32'h0) begin errors++; $display("FAIL reset_rsp: valid %b err %b to %b data %h expected zero", rsp_valid, rsp_error, rsp_timeout, rsp_read_data); end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_write_zero_wait;
      run_xfer(16'h0010, 1'b1, 32'hA5A5_0F0F, 4'hF, 1, 32'hFFFF_FFFF, 1'b0);
      checks++; if (r_psel_at !== 1) begin errors++; $display("FAIL wr_psel_cycle: got %0d expected 1", r_psel_at); end
      checks++; if (r_en_at !== 2) begin errors++; $display("FAIL wr_penable_cycle: got %0d expected 2", r_en_at); end
      checks++; if (r_lat !== 3) begin errors++; $display("FAIL wr_rsp_cycle: got %0d expected 3", r_lat); end
      checks++; if (cap_paddr !== 16'h0010 || cap_pwrite !== 1'b1 || cap_pwdata !== 32'hA5A5_0F0F || cap_pstrb !== 4'hF) begin errors++; $display("FAIL wr_apb_fields: paddr %h pwrite %b pwdata %h pstrb %h expected 0010 1 a5a50f0f f", cap_paddr, cap_pwrite, cap_pwdata, cap_pstrb); end
      checks++; if (rsp_error !== 1'b0 || rsp_timeout !== 1'b0 || rsp_read_data !== 32'h0) begin errors++; $display("FAIL wr_rsp: err %b to %b data %h expected 0 0 0", rsp_error, rsp_timeout, rsp_read_data); end
      checks++; if (apb.psel !== 1'b0 || cmd_ready !== 1'b0) begin errors++; $display("FAIL wr_response_state: psel %b cmd_ready %b expected 0 0", apb.psel, cmd_ready); end
      release_rsp();
      checks++; if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin errors++; $display("FAIL wr_cmd_ready_cycle4: cmd_ready %b rsp_valid %b expected 1 0", cmd_ready, rsp_valid); end
      checks++; if (apb.paddr !== 16'h0010 || apb.pstrb !== 4'hF) begin errors++; $display("FAIL wr_fields_kept: paddr %h pstrb %h expected 0010 f", apb.paddr, apb.pstrb); end
   endtask

   task automatic test_read_wait;
      run_xfer(16'h0020, 1'b0, 32'hDEAD_BEEF, 4'hF, 4, 32'h1234_5678, 1'b0);
      checks++; if (r_en_cycles !== 4) begin errors++; $display("FAIL rd_penable_cycles: got %0d expected 4", r_en_cycles); end
      checks++; if (r_lat !== 6) begin errors++; $display("FAIL rd_rsp_cycle: got %0d expected 6", r_lat); end
      checks++; if (cap_pstrb !== 4'h0 || cap_pwdata !== 32'h0 || cap_pwrite !== 1'b0 || cap_paddr !== 16'h0020) begin errors++; $display("FAIL rd_apb_fields: paddr %h pwrite %b pwdata %h pstrb %h expected 0020 0 0 0", cap_paddr, cap_pwrite, cap_pwdata, cap_pstrb); end
      checks++; if (r_unstable !== 0) begin errors++; $display("FAIL rd_access_stable: got %0d expected 0", r_unstable); end
      checks++; if (rsp_read_data !== 32'h1234_5678 || rsp_error !== 1'b0 || rsp_timeout !== 1'b0) begin errors++; $display("FAIL rd_rsp: data %h err %b to %b expected 12345678 0 0", rsp_read_data, rsp_error, rsp_timeout); end
      release_rsp();
   endtask

   task automatic test_slave_error;
      run_xfer(16'h0004, 1'b1, 32'h0000_BEEF, 4'h3, 1, 32'h0, 1'b1);
      checks++; if (cap_pstrb !== 4'h3 || cap_paddr !== 16'h0004) begin errors++; $display("FAIL err_apb_fields: paddr %h pstrb %h expected 0004 3", cap_paddr, cap_pstrb); end
      checks++; if (rsp_valid !== 1'b1 || rsp_error !== 1'b1 || rsp_timeout !== 1'b0) begin errors++; $display("FAIL err_rsp: valid %b err %b to %b expected 1 1 0", rsp_valid, rsp_error, rsp_timeout); end
      release_rsp();
   endtask

   task automatic test_timeout;
      run_xfer(16'h0008, 1'b0, 32'h0, 4'h0, 0, 32'hFFFF_FFFF, 1'b0);
      checks++; if (r_en_cycles !== 4) begin errors++; $display("FAIL to_penable_cycles: got %0d expected 4", r_en_cycles); end
      checks++; if (r_lat !== 6 || apb.psel !== 1'b0) begin errors++; $display("FAIL to_abort_cycle: rsp cycle %0d psel %b expected 6 0", r_lat, apb.psel); end
      checks++; if (rsp_error !== 1'b1 || rsp_timeout !== 1'b1 || rsp_read_data !== 32'h0) begin errors++; $display("FAIL to_rsp: err %b to %b data %h expected 1 1 0", rsp_error, rsp_timeout, rsp_read_data); end
      release_rsp();
      run_xfer(16'h000C, 1'b1, 32'h5555_AAAA, 4'hC, 4, 32'h0, 1'b0);
      checks++; if (r_en_cycles !== 4 || rsp_timeout !== 1'b0 || rsp_error !== 1'b0) begin errors++; $display("FAIL to_pready_wins: en %0d err %b to %b expected 4 0 0", r_en_cycles, rsp_error, rsp_timeout); end
      release_rsp();
   endtask

   task automatic test_backpressure;
      int bad;
      int n;
      run_xfer(16'h0028, 1'b0, 32'h0, 4'h0, 1, 32'hCAFE_F00D, 1'b0);
      cmd_valid = 1'b1; cmd_address = 16'h0030; cmd_write = 1'b1;
      cmd_write_data = 32'h1111_2222; cmd_strobe = 4'hF;
      bad = 0;
      for (int i = 0; i < 5; i++) begin
         if (!(rsp_valid === 1'b1 && rsp_read_data === 32'hCAFE_F00D && cmd_ready === 1'b0 && apb.psel === 1'b0)) bad++;
         @(negedge clk);
      end
      checks++; if (bad !== 0) begin errors++; $display("FAIL bp_stall_stable: %0d bad cycles expected 0", bad); end
      release_rsp();
      checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL bp_cmd_ready: got %b expected 1", cmd_ready); end
      @(negedge clk);
      cmd_valid = 1'b0;
      checks++; if (apb.psel !== 1'b1 || apb.paddr !== 16'h0030) begin errors++; $display("FAIL bp_second_accept: psel %b paddr %h expected 1 0030", apb.psel, apb.paddr); end
      apb.pready = 1'b1;
      n = 0;
      while (!rsp_valid && n < 20) begin @(negedge clk); n++; end
      apb.pready = 1'b0;
      checks++; if (rsp_valid !== 1'b1 || rsp_read_data !== 32'h0 || rsp_error !== 1'b0) begin errors++; $display("FAIL bp_second_rsp: valid %b data %h err %b expected 1 0 0", rsp_valid, rsp_read_data, rsp_error); end
      release_rsp();
   endtask

   task automatic test_reset_mid_access;
      cmd_valid = 1'b1; cmd_address = 16'h0040; cmd_write = 1'b0;
      apb.pready = 1'b0; apb.prdata = 32'h7777_7777;
      @(negedge clk);
      cmd_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      checks++; if (apb.penable !== 1'b1) begin errors++; $display("FAIL rst_in_access: penable %b expected 1", apb.penable); end
      #2 rst = 1'b1;
      #1;
      checks++; if (apb.psel !== 1'b0 || apb.penable !== 1'b0) begin errors++; $display("FAIL rst_async_drop: psel %b penable %b expected 0 0", apb.psel, apb.penable); end
      @(negedge clk);
      @(negedge clk);
      checks++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_held: rsp_valid %b cmd_ready %b expected 0 1", rsp_valid, cmd_ready); end
      rst = 1'b0;
      apb.pready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      apb.pready = 1'b0;
      checks++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_no_rsp: rsp_valid %b cmd_ready %b expected 0 1", rsp_valid, cmd_ready); end
      run_xfer(16'h0044, 1'b0, 32'h0, 4'h0, 2, 32'h0BAD_CAFE, 1'b0);
      checks++; if (r_lat !== 4 || rsp_read_data !== 32'h0BAD_CAFE || rsp_error !== 1'b0) begin errors++; $display("FAIL rst_fresh_read: cycle %0d data %h err %b expected 4 0badcafe 0", r_lat, rsp_read_data, rsp_error); end
      release_rsp();
   endtask

   initial begin
      rst = 1'b1;
      cmd_valid = 1'b0; cmd_address = '0; cmd_write = 1'b0; cmd_write_data = '0; cmd_strobe = '0;
      rsp_ready = 1'b0;
      apb.pready = 1'b0; apb.prdata = '0; apb.pslverr = 1'b0;
      test_reset();
      test_write_zero_wait();
      test_read_wait();
      test_slave_error();
      test_timeout();
      test_backpressure();
      test_reset_mid_access();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
